// File: rtl/phase_diff_seq.sv
// Voltage/current phase-difference sequencer: launches FFT pairs, captures peak phases,
// averages 2^AVG_LOG2 wrapped differences and reports the result or a timeout.
module phase_diff_seq #(
  parameter int PW       = 17,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 max_done_v,
  input  logic                 max_done_i,
  input  logic [PW-1:0]        theta_o_v,
  input  logic [PW-1:0]        theta_o_i,
  output logic                 fft_start,
  output logic signed [PW-1:0] phase_diff,
  output logic                 phase_diff_done,
  output logic                 timeout_err,
  output logic                 busy
);
  localparam int AW = PW + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] NPAIR = CW'(2 ** AVG_LOG2);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_PAIR, CALC, ACCUM, OUT} state_e;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] theta;
  } cap_t;

  state_e                state_q, state_d;
  cap_t                  cap_v_q, cap_v_d, cap_i_q, cap_i_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic signed [PW-1:0]  pd_q, pd_d;
  logic signed [PW-1:0]  diff_s;
  logic signed [AW-1:0]  diff_ext;
  logic                  fs_c, done_c, err_c;

  // Modular subtraction gives the wrapped difference directly; the signed
  // assignment below sign-extends it into the accumulator width.
  assign diff_s   = signed'(cap_v_q.theta - cap_i_q.theta);
  assign diff_ext = diff_s;

  always_comb begin
    state_d = state_q;
    cap_v_d = cap_v_q;
    cap_i_d = cap_i_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    pd_d    = pd_q;
    fs_c    = 1'b0;
    done_c  = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LAUNCH;
          acc_d   = '0;
          cnt_d   = '0;
          cap_v_d = '0;
          cap_i_d = '0;
        end
      end
      LAUNCH: begin
        fs_c    = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_PAIR;
      end
      WAIT_PAIR: begin
        if (cap_v_q.vld && cap_i_q.vld) begin
          state_d = CALC;
        end else begin
          if (max_done_v && !cap_v_q.vld) cap_v_d = {1'b1, theta_o_v};
          if (max_done_i && !cap_i_q.vld) cap_i_d = {1'b1, theta_o_i};
          tmo_d = tmo_q + 1'b1;
          // A pair completing on the final cycle still counts as in time.
          if (tmo_q == TW'(TIMEOUT - 1) && !(cap_v_d.vld && cap_i_d.vld)) begin
            err_c   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      CALC: begin
        acc_d   = acc_q + diff_ext;
        cnt_d   = cnt_q + 1'b1;
        cap_v_d = '0;
        cap_i_d = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (cnt_q == NPAIR) begin
          pd_d    = PW'(acc_q >>> AVG_LOG2);
          state_d = OUT;
        end else begin
          state_d = LAUNCH;
        end
      end
      OUT: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      pd_d    = pd_q;
      fs_c    = 1'b0;
      done_c  = 1'b0;
      err_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cap_v_q <= '0;
      cap_i_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      cap_v_q <= cap_v_d;
      cap_i_q <= cap_i_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      pd_q    <= pd_d;
    end
  end

  // Pulses are suppressed during a reset cycle so reset never emits an event.
  assign fft_start       = fs_c   && !rst;
  assign phase_diff_done = done_c && !rst;
  assign timeout_err     = err_c  && !rst;
  assign busy            = (state_q != IDLE);
  assign phase_diff      = pd_q;
endmodule

// File: tb/tb_phase_diff_seq.sv
// Directed bench: N=4 and N=1 instances share stimulus; tables of pairs plus
// hand-written duplicate, timeout, abort and reset sequences.
`timescale 1ns/1ps
module tb_phase_diff_seq;
  localparam int PW = 17;

  logic clk = 1'b0;
  logic rst, start, abort, mdv, mdi;
  logic [PW-1:0] tv, ti;
  logic fs4, done4, err4, busy4, fs1, done1, err1, busy1;
  logic signed [PW-1:0] pd4, pd1;
  int n_chk = 0, n_fail = 0;
  int n_fs4 = 0, n_done4 = 0, n_err4 = 0;

  always #500 clk = ~clk;

  phase_diff_seq #(.PW(PW), .AVG_LOG2(2), .TIMEOUT(1000)) u_avg4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .max_done_v(mdv), .max_done_i(mdi), .theta_o_v(tv), .theta_o_i(ti),
    .fft_start(fs4), .phase_diff(pd4), .phase_diff_done(done4),
    .timeout_err(err4), .busy(busy4));

  phase_diff_seq #(.PW(PW), .AVG_LOG2(0), .TIMEOUT(1000)) u_avg1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .max_done_v(mdv), .max_done_i(mdi), .theta_o_v(tv), .theta_o_i(ti),
    .fft_start(fs1), .phase_diff(pd1), .phase_diff_done(done1),
    .timeout_err(err1), .busy(busy1));

  always @(negedge clk) begin
    if (fs4)   n_fs4++;
    if (done4) n_done4++;
    if (err4)  n_err4++;
  end

  typedef struct {
    int v;
    int i;
    int exp;
  } vec1_t;

  typedef struct {
    int d[4];
    int exp;
  } vec4_t;

  vec1_t tbl1[7];
  vec4_t tbl4[3];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_fs(input bit four, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (four ? fs4 : fs1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen) check(name, 0, 1);
  endtask

  // From the LAUNCH cycle: enter WAIT_PAIR, present both phases for one cycle.
  task automatic give_pair(input int v, input int i);
    step();
    tv  = PW'(v);
    ti  = PW'(i);
    mdv = 1'b1;
    mdi = 1'b1;
    step();
    mdv = 1'b0;
    mdi = 1'b0;
  endtask

  // Called one cycle after the completing pulse; done must appear 4 cycles after it.
  task automatic check_lat1(input int exp, input string name);
    bit early = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (done1) early = 1'b1;
      step();
    end
    check({name, "_early"}, early, 0);
    check({name, "_done"}, done1, 1);
    check({name, "_pd"}, pd1, exp);
  endtask

  task automatic run_seq4(input int d[4], input int exp, input string name);
    int b_fs, b_done;
    bit got = 1'b0;
    b_fs   = n_fs4;
    b_done = n_done4;
    pulse_start();
    for (int p = 0; p < 4; p++) begin
      wait_fs(1'b1, {name, "_launch"});
      give_pair(1000 + d[p], 1000);
    end
    for (int k = 0; k < 12; k++) begin
      if (done4) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check({name, "_done"}, got, 1);
    check({name, "_pd"}, pd4, exp);
    step();
    step();
    check({name, "_nfs"}, n_fs4 - b_fs, 4);
    check({name, "_ndone"}, n_done4 - b_done, 1);
    check({name, "_busy"}, busy4, 0);
  endtask

  initial begin
    int cyc, b_done, b_err;
    tbl1[0] = '{100, 131000, 172};
    tbl1[1] = '{400, 1000, -600};
    tbl1[2] = '{0, 0, 0};
    tbl1[3] = '{65535, 0, 65535};
    tbl1[4] = '{0, 65536, -65536};
    tbl1[5] = '{1, 131071, 2};
    tbl1[6] = '{131071, 1, -2};
    tbl4[0] = '{'{600, 600, 600, 600}, 600};
    tbl4[1] = '{'{10, 20, 30, 41}, 25};
    tbl4[2] = '{'{-1, -1, -1, -2}, -2};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mdv = 1'b0; mdi = 1'b0;
    tv = '0; ti = '0;
    step();
    step();
    check("rst_pd", pd4, 0);
    check("rst_done", done4, 0);
    check("rst_fs", fs4, 0);
    check("rst_err", err4, 0);
    check("rst_busy", busy4, 0);
    rst = 1'b0;
    step();

    // Single-sample results; abort afterwards clears the N=4 instance.
    foreach (tbl1[n]) begin
      pulse_start();
      wait_fs(1'b0, "t1_launch");
      give_pair(tbl1[n].v, tbl1[n].i);
      check_lat1(tbl1[n].exp, $sformatf("t1_%0d", n));
      step();
      check($sformatf("t1_%0d_idle", n), busy1, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
    end

    foreach (tbl4[n]) run_seq4(tbl4[n].d, tbl4[n].exp, $sformatf("t4_%0d", n));

    // Duplicate v pulse, then v and i together: first captured v must win.
    pulse_start();
    wait_fs(1'b0, "dup_launch");
    step();
    tv = PW'(300); mdv = 1'b1;
    step();
    tv = PW'(5);
    step();
    tv = PW'(7); ti = PW'(100); mdi = 1'b1;
    step();
    mdv = 1'b0; mdi = 1'b0;
    check_lat1(200, "dup");
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Timeout: only the voltage channel reports.
    pulse_start();
    wait_fs(1'b1, "tmo_launch");
    step();
    tv = PW'(1); mdv = 1'b1;
    step();
    mdv = 1'b0;
    cyc = 2;
    while (!err4 && cyc < 1100) begin
      step();
      cyc++;
    end
    check("tmo_cycle", cyc, 1000);
    check("tmo_err", err4, 1);
    step();
    check("tmo_busy", busy4, 0);
    check("tmo_pd", pd4, -2);
    check("tmo_done", done4, 0);

    // Abort mid-measurement: no pulses, result untouched.
    b_done = n_done4;
    b_err  = n_err4;
    pulse_start();
    wait_fs(1'b1, "abt_launch");
    give_pair(1005, 1000);
    wait_fs(1'b1, "abt_launch2");
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_busy", busy4, 0);
    repeat (10) step();
    check("abt_ndone", n_done4 - b_done, 0);
    check("abt_nerr", n_err4 - b_err, 0);
    check("abt_pd", pd4, -2);

    // Reset during WAIT_PAIR of pair 3, then a clean measurement.
    pulse_start();
    wait_fs(1'b1, "rst_launch1");
    give_pair(3000, 1000);
    wait_fs(1'b1, "rst_launch2");
    give_pair(3000, 1000);
    wait_fs(1'b1, "rst_launch3");
    step();
    tv = PW'(50); mdv = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; mdv = 1'b0;
    check("mrst_pd", pd4, 0);
    check("mrst_done", done4, 0);
    check("mrst_fs", fs4, 0);
    check("mrst_err", err4, 0);
    check("mrst_busy", busy4, 0);
    step();
    run_seq4(tbl4[0].d, 600, "fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
